// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_pkg
//  Purpose  : 640x480@60 raster constants and shared types for the timing gen.
//  Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam bit c_hs_pol   = 1'b0;
    localparam bit c_vs_pol   = 1'b0;
    localparam int c_rd_lat   = 2;
    localparam int c_cw       = 12;

    localparam int c_h_total = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    // Bundle carried through the delay line; hs/vs are stored at output polarity.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic frame_start;
        logic line_start;
    } timing_bits_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen_if
//  Purpose  : Raster timing / pixel-request bundle between generator and sink.
//  Revision : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int CW = 12
) ();

    logic          en;
    logic          data_req;
    logic [CW-1:0] req_x;
    logic [CW-1:0] req_y;
    logic          de;
    logic          hs;
    logic          vs;
    logic          frame_start;
    logic          line_start;

    modport master (
        input  en,
        output data_req, req_x, req_y,
        output de, hs, vs, frame_start, line_start
    );

    modport slave (
        output en,
        input  data_req, req_x, req_y,
        input  de, hs, vs, frame_start, line_start
    );

endinterface
`default_nettype wire

// File: rtl/video_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : sync_delay_line
//  Purpose  : Enable-gated shift register with a per-bit reset value.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              en,
    input  wire  [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("sync_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RST_VAL;
            end
        end else if (en) begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Raster timing with early pixel request and latency-matched syncs.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit HS_POL   = c_hs_pol,
    parameter bit VS_POL   = c_vs_pol,
    parameter int RD_LAT   = c_rd_lat,
    parameter int CW       = c_cw
) (
    input wire                 clk,
    input wire                 rst,
    video_timing_gen_if.master vt
);

    localparam int c_ht       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_vt       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CW-1:0] c_h_last = CW'(c_ht - 1);
    localparam logic [CW-1:0] c_v_last = CW'(c_vt - 1);

    localparam timing_bits_t c_idle = '{
        de:          1'b0,
        hs:          ~HS_POL,
        vs:          ~VS_POL,
        frame_start: 1'b0,
        line_start:  1'b0
    };

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("video_timing_gen: RD_LAT must be within 1..4");
    end
    if (CW < 2 || CW > 30) begin : g_bad_cw
        $error("video_timing_gen: CW must be within 2..30");
    end
    if (c_ht > (1 << CW) || c_vt > (1 << CW)) begin : g_bad_geometry
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [CW-1:0] r_req_x;
    logic [CW-1:0] r_req_y;
    timing_bits_t  r_stage1;
    timing_bits_t  w_stage0;
    timing_bits_t  w_delayed;
    logic          w_h_active;
    logic          w_v_active;
    logic          w_hs_active;
    logic          w_vs_active;

    // Stage 0: raster position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (vt.en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_h_active  = int'(r_h_cnt) < H_ACTIVE;
        w_v_active  = int'(r_v_cnt) < V_ACTIVE;
        w_hs_active = (int'(r_h_cnt) >= c_hs_start) && (int'(r_h_cnt) < c_hs_end);
        w_vs_active = (int'(r_v_cnt) >= c_vs_start) && (int'(r_v_cnt) < c_vs_end);

        w_stage0             = c_idle;
        w_stage0.de          = w_h_active & w_v_active;
        w_stage0.hs          = sync_level(w_hs_active, HS_POL);
        w_stage0.vs          = sync_level(w_vs_active, VS_POL);
        w_stage0.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_stage0.line_start  = (r_h_cnt == '0);
    end

    // Stage 1: the request side; its de bit doubles as data_req.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1 <= c_idle;
            r_req_x  <= '0;
            r_req_y  <= '0;
        end else if (vt.en) begin
            r_stage1 <= w_stage0;
            if (w_stage0.de) begin
                r_req_x <= r_h_cnt;
                r_req_y <= r_v_cnt;
            end
        end
    end

    sync_delay_line #(
        .WIDTH   ($bits(timing_bits_t)),
        .DEPTH   (RD_LAT),
        .RST_VAL (c_idle)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (vt.en),
        .din  (r_stage1),
        .dout (w_delayed)
    );

    assign vt.data_req    = r_stage1.de;
    assign vt.req_x       = r_req_x;
    assign vt.req_y       = r_req_y;
    assign vt.de          = w_delayed.de;
    assign vt.hs          = w_delayed.hs;
    assign vt.vs          = w_delayed.vs;
    assign vt.frame_start = w_delayed.frame_start;
    assign vt.line_start  = w_delayed.line_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Edge-timing scoreboard for two small-raster generator instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    // Reduced raster so whole frames fit a short run: 32 x 17 = 544 cycles.
    localparam int HA = 16, HFP = 4, HSY = 6, HBP = 6, HT = 32;
    localparam int VA = 10, VFP = 2, VSY = 2, VBP = 3, VT = 17;
    localparam int FRAME = HT * VT;
    localparam int LAT_A = 2, LAT_B = 4;
    localparam int GAP = 7;

    localparam int K_REQ = 0, K_DE_R = 1, K_DE_F = 2, K_HS_A = 3, K_HS_I = 4;
    localparam int K_VS_A = 5, K_VS_I = 6, K_FS_R = 7, K_FS_F = 8, K_LS_R = 9, K_LS_F = 10;
    localparam int NK = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;

    int   q [2*NK][$];
    int   qx[$];
    int   qy[$];
    logic [5:0] now_a, now_b, prev_a, prev_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_timing_gen_if #(.CW(12)) vif_a ();
    video_timing_gen_if #(.CW(12)) vif_b ();
    assign vif_a.en = en;
    assign vif_b.en = en;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(LAT_A), .CW(12)
    ) dut_a (.clk(clk), .rst(rst), .vt(vif_a));

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(LAT_B), .CW(12)
    ) dut_b (.clk(clk), .rst(rst), .vt(vif_b));

    task automatic expect_eq(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Edge at nominal cycle c moves by GAP once the freeze has happened.
    function automatic bit add(input int d, input int k, input int c,
                               input int gap_at, input int horizon);
        int t;
        t = (c >= gap_at) ? c + GAP : c;
        if (t <= horizon) begin
            q[d*NK+k].push_back(t);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic gen_events(input int t0, input int gap_at, input int horizon);
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 3; f++) begin
                for (int l = 0; l < VT; l++) begin
                    int lat;
                    int b;
                    lat = (d == 0) ? LAT_A : LAT_B;
                    b   = t0 + f*FRAME + l*HT + 1;
                    if (l < VA) begin
                        if (add(d, K_REQ, b, gap_at, horizon) && d == 0) begin
                            qx.push_back(0);
                            qy.push_back(l);
                        end
                        void'(add(d, K_DE_R, b + lat, gap_at, horizon));
                        void'(add(d, K_DE_F, b + lat + HA, gap_at, horizon));
                    end
                    void'(add(d, K_HS_A, b + lat + HA + HFP, gap_at, horizon));
                    void'(add(d, K_HS_I, b + lat + HA + HFP + HSY, gap_at, horizon));
                    void'(add(d, K_LS_R, b + lat, gap_at, horizon));
                    void'(add(d, K_LS_F, b + lat + 1, gap_at, horizon));
                    if (l == 0) begin
                        void'(add(d, K_FS_R, b + lat, gap_at, horizon));
                        void'(add(d, K_FS_F, b + lat + 1, gap_at, horizon));
                    end
                    if (l == VA + VFP) void'(add(d, K_VS_A, b + lat, gap_at, horizon));
                    if (l == VA + VFP + VSY) void'(add(d, K_VS_I, b + lat, gap_at, horizon));
                end
            end
        end
    endtask

    task automatic pop_chk(input int d, input int k, input string nm);
        int idx;
        int e;
        idx = d*NK + k;
        total++;
        if (q[idx].size() == 0) begin
            bad++;
            $display("FAIL %s dut%0d: edge at cycle %0d, none required", nm, d, cyc);
        end else begin
            e = q[idx].pop_front();
            if (e != cyc) begin
                bad++;
                $display("FAIL %s dut%0d: edge at cycle %0d, required %0d", nm, d, cyc, e);
            end
        end
    endtask

    task automatic watch(input int d, input logic nw, input logic pv,
                         input int kr, input int kf, input string nm);
        if (nw && !pv) pop_chk(d, kr, {nm, "_rise"});
        if (!nw && pv && kf >= 0) pop_chk(d, kf, {nm, "_fall"});
    endtask

    task automatic scan(input int d, input logic [5:0] nw, input logic [5:0] pv);
        watch(d, nw[5], pv[5], K_REQ, -1, "data_req");
        watch(d, nw[4], pv[4], K_DE_R, K_DE_F, "de");
        watch(d, nw[3], pv[3], K_HS_A, K_HS_I, "hs_active");
        watch(d, nw[2], pv[2], K_VS_A, K_VS_I, "vs_active");
        watch(d, nw[1], pv[1], K_FS_R, K_FS_F, "frame_start");
        watch(d, nw[0], pv[0], K_LS_R, K_LS_F, "line_start");
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            now_a = {vif_a.data_req, vif_a.de, vif_a.hs == 1'b0, vif_a.vs == 1'b0,
                     vif_a.frame_start, vif_a.line_start};
            now_b = {vif_b.data_req, vif_b.de, vif_b.hs == 1'b1, vif_b.vs == 1'b1,
                     vif_b.frame_start, vif_b.line_start};
            if (mon_on) begin
                scan(0, now_a, prev_a);
                scan(1, now_b, prev_b);
                if (now_a[5] && !prev_a[5] && qx.size() > 0) begin
                    expect_eq("req_x_at_line_start", int'(vif_a.req_x), qx.pop_front());
                    expect_eq("req_y_at_line_start", int'(vif_a.req_y), qy.pop_front());
                end
            end
            prev_a = now_a;
            prev_b = now_b;
        end
    end

    task automatic drain(input string phase);
        for (int i = 0; i < 2*NK; i++) begin
            total++;
            if (q[i].size() != 0) begin
                bad++;
                $display("FAIL %s queue %0d: %0d required edges not seen, first at %0d",
                         phase, i, q[i].size(), q[i][0]);
                q[i].delete();
            end
        end
        qx.delete();
        qy.delete();
    endtask

    task automatic check_idle(input string nm);
        expect_eq({nm, "_a_data_req"}, int'(vif_a.data_req), 0);
        expect_eq({nm, "_a_req_x"}, int'(vif_a.req_x), 0);
        expect_eq({nm, "_a_req_y"}, int'(vif_a.req_y), 0);
        expect_eq({nm, "_a_de"}, int'(vif_a.de), 0);
        expect_eq({nm, "_a_hs"}, int'(vif_a.hs), 1);
        expect_eq({nm, "_a_vs"}, int'(vif_a.vs), 1);
        expect_eq({nm, "_a_frame_start"}, int'(vif_a.frame_start), 0);
        expect_eq({nm, "_a_line_start"}, int'(vif_a.line_start), 0);
        expect_eq({nm, "_b_de"}, int'(vif_b.de), 0);
        expect_eq({nm, "_b_hs"}, int'(vif_b.hs), 0);
        expect_eq({nm, "_b_vs"}, int'(vif_b.vs), 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");

        // Two free-running frames from reset release.
        rst = 1'b0;
        t0  = cyc;
        gen_events(t0, 32'h7fff_ffff, t0 + 2*FRAME);
        mon_on = 1'b1;
        wait_cyc(t0 + 2*FRAME);
        mon_on = 1'b0;
        drain("run");

        // One-cycle reset with the counters at h=10, v=5.
        wait_cyc(t0 + 2*FRAME + 5*HT + 10);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        t0  = cyc;
        gen_events(t0, t0 + 1 + 2*HT + 5 + 1, t0 + 2*FRAME + GAP);
        mon_on = 1'b1;

        // Freeze while req_x = 5 on row 2.
        wait_cyc(t0 + 1 + 2*HT + 5);
        en = 1'b0;
        for (int i = 1; i <= GAP; i++) begin
            @(negedge clk);
            expect_eq("freeze_a_data_req", int'(vif_a.data_req), 1);
            expect_eq("freeze_a_req_x", int'(vif_a.req_x), 5);
            expect_eq("freeze_a_req_y", int'(vif_a.req_y), 2);
            expect_eq("freeze_a_de", int'(vif_a.de), 1);
            expect_eq("freeze_a_hs", int'(vif_a.hs), 1);
            expect_eq("freeze_a_vs", int'(vif_a.vs), 1);
            expect_eq("freeze_a_frame_start", int'(vif_a.frame_start), 0);
            expect_eq("freeze_a_line_start", int'(vif_a.line_start), 0);
            expect_eq("freeze_b_de", int'(vif_b.de), 1);
            expect_eq("freeze_b_hs", int'(vif_b.hs), 0);
        end
        en = 1'b1;
        @(negedge clk);
        expect_eq("resume_a_data_req", int'(vif_a.data_req), 1);
        expect_eq("resume_a_req_x", int'(vif_a.req_x), 6);
        expect_eq("resume_a_req_y", int'(vif_a.req_y), 2);

        wait_cyc(t0 + 2*FRAME + GAP);
        mon_on = 1'b0;
        drain("gap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI/DVI transmit path in the pixel-clock domain.
- The pixel clock is derived from the TX rPLL output: the 124.875 MHz serial clock divided by 5 gives 24.975 MHz.
- Issues a pixel-data request ahead of the display enable, so the frame-buffer read path (fixed latency RD_LAT) delivers pixels aligned with de.
- Sync outputs are delayed to match, and the encoder/serializer consumes de/hs/vs directly.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- RD_LAT, 2, cycles from data_req to pixel valid at consumer; legal range 1..4
- CW, 12, counter width

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; when low, counters and pipeline freeze
- data_req  out  1  request pixel at (req_x, req_y)
- req_x  out  CW  active-area column of request, 0..H_ACTIVE-1
- req_y  out  CW  active-area row of request, 0..V_ACTIVE-1
- de  out  1  display enable, delayed RD_LAT cycles after data_req
- hs  out  1  hsync, polarity HS_POL, same delay as de
- vs  out  1  vsync, polarity VS_POL, same delay as de
- frame_start  out  1  one-cycle pulse, same delay as de, when the delayed raster reaches h=0, v=0
- line_start  out  1  one-cycle pulse, same delay as de, at every h=0

Behaviour:
- H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params.
- Stage-0 counters h_cnt and v_cnt.
  - Each cycle with en=1: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 on the same cycle h_cnt wraps.
- Raster order per line: active [0, H_ACTIVE), FP, SYNC, BP.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - Vertical regions follow the same order, with vsync asserted on whole lines.
- data_req, req_x, req_y are registered from stage-0 state: one cycle after the counters.
  - data_req = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - req_x/req_y = h_cnt/v_cnt when data_req is 1; otherwise they hold their last value.
- de/hs/vs/frame_start/line_start come from a shift pipeline.
  - They are exactly RD_LAT cycles later than the data_req of the same raster position.
  - The pipeline advances only when en=1.
- Reset (synchronous, any time including mid-frame) forces:
  - h_cnt = v_cnt = 0
  - whole pipeline cleared
  - data_req = 0, req_x = req_y = 0
  - de = 0, frame_start = 0, line_start = 0
  - hs = ~HS_POL, vs = ~VS_POL (inactive)
- After rst deassert with en=1:
  - First data_req = 1 on cycle 1, with req_x = 0, req_y = 0.
  - First de = 1 and first frame_start on cycle 1+RD_LAT.
  - Pipeline fill slots output inactive levels, never spurious pulses.
- en low mid-line: all outputs hold their current values; resuming continues seamlessly with no skipped pixels.
- Simultaneous rst and en: rst wins.
- Counter widths are CW bits; H_TOTAL and V_TOTAL must be at most 2^CW. An elaboration-time check fails otherwise, and also fails for RD_LAT outside 1..4.

Decomposition:
- Shared package video_timing_pkg holds:
  - 640x480@60 default constants (H/V active, porch, sync, polarities)
  - derived H_TOTAL and V_TOTAL
  - CW
- One sub-module, sync_delay_line: parameterised-depth, enable-gated shift register with a per-bit reset value. It carries de/hs/vs/frame_start/line_start RD_LAT stages.

Test Plan:
1. Reset release, en=1, defaults:
   - data_req rises 1 cycle after rst low, with req_x=0, req_y=0.
   - de rises 3 cycles after rst low.
   - frame_start pulses once on that same cycle.
2. Line timing over 2 lines:
   - data_req high 640 cycles and low 160; period 800.
   - hs low exactly 96 cycles, starting 656 cycles after each de rise.
3. Full frame:
   - frame_start period 420000 cycles.
   - 480 de-high lines per frame.
   - vs low for 1600 cycles (2 lines), starting at line 490 of de timing.
4. Pipeline alignment with RD_LAT=4: every de rise is exactly 4 cycles after the matching data_req rise, checked at req_x=0 for all 480 rows.
5. en toggled low for 7 cycles at req_x=100:
   - Outputs frozen during the gap.
   - Next req_x = 101.
   - Frame period extends by exactly 7 cycles.
6. rst asserted at h=300, v=200 for 1 cycle:
   - Next cycle de=0, hs=1, vs=1, data_req=0.
   - Restart proceeds exactly as in scenario 1.
